// File: rtl/frame_sequencer_pkg.sv
// Shared types and constants for the frame sequencer and the processing block.
// Opcode encoding, FSM state encoding, coordinate width and the write-coordinate map.
package frame_sequencer_pkg;

  localparam int unsigned CoordW = 12;
  localparam int unsigned ParamW = 8;
  localparam int unsigned JobW   = 2 + ParamW;

  typedef enum logic [1:0] {
    OpBrightness = 2'd0,
    OpGrayscale  = 2'd1,
    OpRotate     = 2'd2,
    OpReserved   = 2'd3
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StDrain,
    StDone
  } state_e;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [ParamW-1:0] param;
  } job_t;

  typedef struct packed {
    logic [CoordW-1:0] row;
    logic [CoordW-1:0] col;
  } coord_t;

  // Rotate is 90 degrees clockwise; row < height, so height-1-row cannot underflow.
  function automatic coord_t map_coord(input logic [1:0]        op,
                                       input logic [CoordW-1:0] row,
                                       input logic [CoordW-1:0] col,
                                       input logic [CoordW-1:0] height);
    coord_t c;
    if (op == OpRotate) begin
      c.row = col;
      c.col = height - row - CoordW'(1);
    end else begin
      c.row = row;
      c.col = col;
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_sequencer_job_fifo.sv
// Synchronous job FIFO with registered occupancy count and full/empty flags.
// Head entry is presented combinationally on rdata.
module job_fifo #(
  parameter int unsigned Width = 10,
  parameter int unsigned Depth = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/frame_sequencer.sv
// Job scheduler and raster address sequencer feeding the image writer.
// Optional FRAME_SEQUENCER_STATS_EN adds frame_count / pixel_count outputs.
module frame_sequencer
  import frame_sequencer_pkg::*;
#(
  parameter int unsigned QDEPTH   = 4,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              job_valid,
  output logic              job_ready,
  input  logic [1:0]        job_opcode,
  input  logic [ParamW-1:0] job_param,
  input  logic [CoordW-1:0] src_width,
  input  logic [CoordW-1:0] src_height,
  output logic [CoordW-1:0] read_row,
  output logic [CoordW-1:0] read_col,
  output logic [1:0]        opcode,
  output logic [ParamW-1:0] param,
  output logic              write_en,
  output logic [CoordW-1:0] write_row,
  output logic [CoordW-1:0] write_col,
  output logic [CoordW-1:0] write_width,
  output logic [CoordW-1:0] write_height,
  output logic              busy,
  output logic              frame_done,
  output logic              err
`ifdef FRAME_SEQUENCER_STATS_EN
  ,
  output logic [15:0]       frame_count,
  output logic [31:0]       pixel_count
`endif
);

  localparam int unsigned DrainW = $clog2(PIPE_LAT + 1);

  state_e state_q, state_d;

  logic              fifo_full, fifo_empty, fifo_push;
  job_t              push_job, head_job;
  logic              load, scan, last_pix, drain_last, zero_dim;
  logic [1:0]        op_q;
  logic [ParamW-1:0] param_q;
  logic [CoordW-1:0] w_q, h_q, row_q, col_q, wr_w_q, wr_h_q;
  logic [DrainW-1:0] drain_cnt_q;
  logic              err_q;
  coord_t            issue;
  logic              pipe_en_q [PIPE_LAT];
  coord_t            pipe_xy_q [PIPE_LAT];

  // Reserved opcodes are never queued; they only raise the sticky error.
  assign push_job  = '{opcode: job_opcode, param: job_param};
  assign fifo_push = job_valid && !fifo_full && (job_opcode != OpReserved);
  assign job_ready = !fifo_full;

  job_fifo #(
    .Width(JobW),
    .Depth(QDEPTH)
  ) u_job_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (fifo_push),
    .wdata(push_job),
    .pop  (load),
    .rdata(head_job),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign zero_dim   = (src_width == '0) || (src_height == '0);
  assign last_pix   = (col_q == w_q - CoordW'(1)) && (row_q == h_q - CoordW'(1));
  assign drain_last = (drain_cnt_q == DrainW'(PIPE_LAT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StLoad;
      StLoad:  state_d = zero_dim ? StDone : StScan;
      StScan:  if (last_pix) state_d = StDrain;
      StDrain: if (drain_last) state_d = StDone;
      StDone:  state_d = fifo_empty ? StIdle : StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load       = (state_q == StLoad);
    scan       = (state_q == StScan);
    busy       = (state_q != StIdle);
    frame_done = (state_q == StDone);
  end

  // Scan counters return to zero after the last pixel so the read address idles at (0,0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q        <= '0;
      param_q     <= '0;
      w_q         <= '0;
      h_q         <= '0;
      wr_w_q      <= '0;
      wr_h_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      if (job_valid && !fifo_full && (job_opcode == OpReserved)) begin
        err_q <= 1'b1;
      end
      if (load) begin
        op_q    <= head_job.opcode;
        param_q <= head_job.param;
        w_q     <= src_width;
        h_q     <= src_height;
        row_q   <= '0;
        col_q   <= '0;
        if (head_job.opcode == OpRotate) begin
          wr_w_q <= src_height;
          wr_h_q <= src_width;
        end else begin
          wr_w_q <= src_width;
          wr_h_q <= src_height;
        end
      end else if (scan) begin
        if (col_q == w_q - CoordW'(1)) begin
          col_q <= '0;
          row_q <= (row_q == h_q - CoordW'(1)) ? '0 : row_q + CoordW'(1);
        end else begin
          col_q <= col_q + CoordW'(1);
        end
      end
      drain_cnt_q <= (state_q == StDrain) ? drain_cnt_q + 1'b1 : '0;
    end
  end

  assign issue = map_coord(op_q, row_q, col_q, h_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < PIPE_LAT; i++) begin
        pipe_en_q[i] <= 1'b0;
        pipe_xy_q[i] <= '0;
      end
    end else begin
      pipe_en_q[0] <= scan;
      pipe_xy_q[0] <= scan ? issue : '0;
      for (int unsigned i = 1; i < PIPE_LAT; i++) begin
        pipe_en_q[i] <= pipe_en_q[i-1];
        pipe_xy_q[i] <= pipe_xy_q[i-1];
      end
    end
  end

  assign read_row     = row_q;
  assign read_col     = col_q;
  assign opcode       = op_q;
  assign param        = param_q;
  assign write_en     = pipe_en_q[PIPE_LAT-1];
  assign write_row    = pipe_xy_q[PIPE_LAT-1].row;
  assign write_col    = pipe_xy_q[PIPE_LAT-1].col;
  assign write_width  = wr_w_q;
  assign write_height = wr_h_q;
  assign err          = err_q;

`ifdef FRAME_SEQUENCER_STATS_EN
  logic [15:0] frame_count_q;
  logic [31:0] pixel_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_count_q <= '0;
      pixel_count_q <= '0;
    end else begin
      if (frame_done) frame_count_q <= frame_count_q + 16'd1;
      if (write_en)   pixel_count_q <= pixel_count_q + 32'd1;
    end
  end

  assign frame_count = frame_count_q;
  assign pixel_count = pixel_count_q;
`endif

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Job scheduler and address sequencer for the image pipeline. Queues processing jobs (opcode + parameter) from a host/testbench and runs each one over the frame held by the image reader. For each job it raster-scans the reader, drives the processing opcode, and produces aligned write coordinates, dimensions and a write strobe for the image writer. It signals frame completion per job.

## Interface
- QDEPTH, 4, job FIFO depth (power of 2, ≥2)
- PIPE_LAT, 2, cycles from READ_ROW/COL issue to processed pixel at writer input (≥1)
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-high
- JOB_VALID  in  1  job request
- JOB_READY  out  1  FIFO not full
- JOB_OPCODE  in  2  0=BRIGHTNESS, 1=GRAYSCALE, 2=ROTATE, 3=reserved
- JOB_PARAM  in  8  job parameter (brightness offset)
- SRC_WIDTH, SRC_HEIGHT  in  12 each  frame dims from reader
- READ_ROW, READ_COL  out  12 each  scan address to reader
- OPCODE  out  2  active job opcode to processing
- PARAM  out  8  active job parameter
- WRITE_EN  out  1  processed pixel valid at writer
- WRITE_ROW, WRITE_COL  out  12 each  destination coordinate, aligned with WRITE_EN
- WRITE_WIDTH, WRITE_HEIGHT  out  12 each  output frame dims
- BUSY  out  1  a job is active (state ≠ IDLE)
- FRAME_DONE  out  1  one-cycle pulse at job completion
- ERR  out  1  sticky: reserved opcode received

## Operation
- Push on JOB_VALID & JOB_READY. JOB_READY = (count ≠ QDEPTH), combinational; 1 during and after reset.
- Opcode 3 is never enqueued; on handshake ERR sets, sticky until RESET.
- FSM states: IDLE → LOAD when FIFO non-empty. LOAD pops the head, latches OPCODE/PARAM/SRC dims, and computes output dims. LOAD → SCAN, or LOAD → DONE when SRC_WIDTH==0 or SRC_HEIGHT==0. SCAN → DRAIN after last pixel. DRAIN → DONE after PIPE_LAT cycles. DONE → LOAD if FIFO non-empty, else IDLE.
- SCAN order is row-major, COL fastest: (0,0),(0,1)…(0,W-1),(1,0)…(H-1,W-1). One address per cycle, no bubbles.
- Coordinate map, applied at issue and delayed PIPE_LAT:
  - BRIGHTNESS/GRAYSCALE: write = (row, col); WRITE_WIDTH=W, WRITE_HEIGHT=H.
  - ROTATE (90° CW): write_row = col, write_col = H-1-row; WRITE_WIDTH=H, WRITE_HEIGHT=W.
- WRITE_ROW/COL are 12-bit. H-1-row never underflows because row<H.
- A push and a pop may occur in the same cycle; count is unchanged.
- RESET mid-job: FIFO flushed, FSM→IDLE, no FRAME_DONE.

## Timing
- Reset values:
  - all outputs 0 except JOB_READY=1.
  - OPCODE/PARAM/WRITE_WIDTH/WRITE_HEIGHT hold their last job's values after DONE.
- A job pushed into an empty FIFO in IDLE at edge N enters LOAD at edge N+1.
- The first address is valid the cycle after LOAD. WRITE_EN rises PIPE_LAT cycles after the first address and stays high W·H cycles.
- FRAME_DONE asserts in the DONE cycle, 1+W·H+PIPE_LAT cycles after LOAD.
- Back-to-back jobs: DONE→LOAD adds 2 idle cycles between frames.
- Zero-dim job: LOAD then DONE, with no WRITE_EN.

## Configuration
- FRAME_SEQUENCER_STATS_EN defined: adds outputs FRAME_COUNT[15:0] (completed jobs) and PIXEL_COUNT[31:0] (WRITE_EN cycles). Both are reset to 0 and wrap on overflow.
- FRAME_SEQUENCER_STATS_EN undefined: these ports and their counters are absent. All other behaviour is identical.

## Structure
- The shared package holds the opcode constants (BRIGHTNESS=0, GRAYSCALE=1, ROTATE=2, RESERVED=3), the FSM state encoding, and a 12-bit coordinate width constant. The processing block uses the same package.
- One sub-module: `job_fifo` (synchronous FIFO, width 10, depth QDEPTH, registered count, full/empty).
- The PIPE_LAT delay line for WRITE_EN/ROW/COL stays inline.

## Test plan
- BRIGHTNESS, PARAM=20, W=3 H=2:
  - READ sequence is (0,0)(0,1)(0,2)(1,0)(1,1)(1,2).
  - WRITE_EN is high 6 cycles, starting 2 cycles after first read, with identical coordinates.
  - FRAME_DONE fires 9 cycles after LOAD.
- ROTATE, W=3 H=2:
  - WRITE_WIDTH=2, WRITE_HEIGHT=3.
  - read (0,0)→write (0,1); (0,2)→(2,1); (1,2)→(2,0).
- Queue full, QDEPTH=4: push 6 jobs back-to-back while the first runs.
  - JOB_READY=0 after 5 accepted (1 active + 4 queued).
  - Jobs complete in push order; 5 FRAME_DONE then 1 more.
- SRC_WIDTH=0: no READ/WRITE_EN, FRAME_DONE 1 cycle after LOAD, BUSY returns 0.
- JOB_OPCODE=3 pushed: ERR=1, no job runs, FIFO count unchanged. ERR stays set until RESET.
- RESET pulsed mid-SCAN with 2 jobs queued: all outputs return to reset values, no FRAME_DONE, FIFO empty.
